// File: rtl/seq_tx_pkg.sv
// seq_tx_pkg: shared types and constants for the "110" serial sync link transmitter.
package seq_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        PAR,
        GAP
    } state_t;

    // Marker the downstream Mealy detector fires on; sent MSB first.
    localparam logic [2:0] SYNC_PATTERN = 3'b110;
    localparam int         SYNC_LEN     = 3;

endpackage

// File: rtl/seq_tx_shreg.sv
// seq_tx_shreg: loadable left-shift register; msb is the next payload bit to send.
module seq_tx_shreg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
);

    logic [DATA_W-1:0] data_d, data_q;

    // Load has priority; shifting pulls the next lower bit into the msb position.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = din;
        end else if (shift) begin
            data_d = data_q << 1;
        end
    end

    // Payload storage, cleared by synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign msb = data_q[DATA_W-1];

endmodule

// File: rtl/seq110_frame_tx.sv
// seq110_frame_tx: framed serial transmitter (marker 110, MSB-first payload, idle gap).
// Optional feature: define SEQ_TX_PARITY_EN to append an even-parity bit after the payload.
module seq110_frame_tx
    import seq_tx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] din,
    output logic              in_ready,
    output logic              sout,
    output logic              busy,
    output logic              tx_done
);

    localparam int CNT_MAX = (DATA_W > GAP_CYC) ? DATA_W : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [1:0]       SYNC_LAST = 2'(SYNC_LEN - 1);

    state_t           state_d, state_q;
    logic [1:0]       sync_cnt_d, sync_cnt_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             sout_d, sout_q;
    logic             busy_d, busy_q;
    logic             in_ready_d, in_ready_q;
    logic             tx_done_d, tx_done_q;
    logic             sh_load, sh_shift, sh_msb;
`ifdef SEQ_TX_PARITY_EN
    logic             parity_d, parity_q;
`endif

    seq_tx_shreg #(.DATA_W(DATA_W)) u_shreg (
        .clk   (clk),
        .reset (reset),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (din),
        .msb   (sh_msb)
    );

    // Next state and next registered outputs; each state computes the bit for the following cycle.
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        cnt_d      = cnt_q;
        sout_d     = 1'b0;
        busy_d     = busy_q;
        in_ready_d = in_ready_q;
        tx_done_d  = 1'b0;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
`ifdef SEQ_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sh_load    = 1'b1;
                    state_d    = SYNC;
                    sync_cnt_d = '0;
                    sout_d     = SYNC_PATTERN[SYNC_LEN-1];
                    busy_d     = 1'b1;
                    in_ready_d = 1'b0;
`ifdef SEQ_TX_PARITY_EN
                    parity_d   = ^din;
`endif
                end
            end
            SYNC: begin
                if (sync_cnt_q == SYNC_LAST) begin
                    state_d  = DATA;
                    cnt_d    = '0;
                    sout_d   = sh_msb;
                    sh_shift = 1'b1;
                end else begin
                    sync_cnt_d = sync_cnt_q + 2'd1;
                    sout_d     = SYNC_PATTERN[2'(SYNC_LEN - 2) - sync_cnt_q];
                end
            end
            DATA: begin
                if (cnt_q == DATA_LAST) begin
`ifdef SEQ_TX_PARITY_EN
                    state_d   = PAR;
                    sout_d    = parity_q;
`else
                    state_d   = GAP;
                    cnt_d     = '0;
                    tx_done_d = 1'b1;
`endif
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    sout_d   = sh_msb;
                    sh_shift = 1'b1;
                end
            end
`ifdef SEQ_TX_PARITY_EN
            PAR: begin
                state_d   = GAP;
                cnt_d     = '0;
                tx_done_d = 1'b1;
            end
`endif
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    in_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                in_ready_d = 1'b1;
            end
        endcase
    end

    // State, counters and output registers; reset aborts any frame without a tx_done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            sync_cnt_q <= '0;
            cnt_q      <= '0;
            sout_q     <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
            tx_done_q  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            cnt_q      <= cnt_d;
            sout_q     <= sout_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
            tx_done_q  <= tx_done_d;
`ifdef SEQ_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign sout     = sout_q;
    assign busy     = busy_q;
    assign in_ready = in_ready_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_seq110_frame_tx.sv
// tb_seq110_frame_tx: scoreboard bench for seq110_frame_tx, with a 110 Mealy detector on the line.
module tb_seq110_frame_tx;

    localparam int DW  = 8;
    localparam int GAP = 2;
`ifdef SEQ_TX_PARITY_EN
    localparam int PARB = 1;
`else
    localparam int PARB = 0;
`endif
    localparam int L = 3 + DW + PARB + GAP;
    // {sout, tx_done, busy, in_ready} when idle
    localparam logic [3:0] IDLE_V = 4'b0001;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] din;
    logic          in_ready, sout, busy, tx_done;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];
    logic       rst_seen = 1'b0;
    int         cyc = 0, since = 0, acc_cnt = 0, last_acc = 0;
    int         y_cnt = 0, y_at = 0;
    logic       h1 = 1'b0, h2 = 1'b0;
    logic       b2b = 1'b0, b2b_have = 1'b0;

    seq110_frame_tx #(.DATA_W(DW), .GAP_CYC(GAP)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .din      (din),
        .in_ready (in_ready),
        .sout     (sout),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) if (!reset) rst_seen <= 1'b1;

    // Monitor: compare line state every cycle, run the 110 detector, push frames on handshakes.
    always @(negedge clk) begin
        logic [3:0] e, g;
        logic       y, s;
        cyc++;
        if (rst_seen) begin
            g = {sout, tx_done, busy, in_ready};
            e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
            chk("line", g, e);
            since++;
            y = (sout == 1'b0) && h1 && h2;
            if (y) begin
                y_cnt++;
                y_at = since;
            end
            h2 = h1;
            h1 = sout;
            if (!b2b) b2b_have = 1'b0;
            if (!reset) begin
                exp_q.delete();
                exp_q.push_back(IDLE_V);
                h1 = 1'b0;
                h2 = 1'b0;
            end else if (in_valid && in_ready) begin
                for (int k = 0; k < L; k++) begin
                    if (k == 0 || k == 1)        s = 1'b1;
                    else if (k == 2)             s = 1'b0;
                    else if (k < 3 + DW)         s = din[DW-1-(k-3)];
                    else if (PARB == 1 && k == 3 + DW) s = ^din;
                    else                         s = 1'b0;
                    exp_q.push_back({s, (k == 3 + DW + PARB), 1'b1, 1'b0});
                end
                exp_q.push_back(IDLE_V);
                if (b2b) begin
                    if (b2b_have) chk("period", cyc - last_acc, L + 1);
                    b2b_have = 1'b1;
                end
                acc_cnt++;
                last_acc = cyc;
                since = 0;
            end
        end
    end

    task automatic send(input logic [DW-1:0] w);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        din = w;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_frame();
        repeat (L + 2) @(posedge clk);
        #1;
    endtask

    initial begin
        int base, yb;
        reset = 1'b0;
        in_valid = 1'b0;
        din = '0;
        // reset held for two edges; monitor expects idle outputs
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 1);

        // basic frame, A5
        send(8'hA5);
        wait_frame();
        // parity payload (parity only present with macro)
        send(8'h07);
        wait_frame();

        // held valid with changing din: back-to-back frames
        base = acc_cnt;
        b2b = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4 * (L + 1) && acc_cnt < base + 3; i++) begin
            @(posedge clk);
            #1 din = DW'($urandom);
        end
        in_valid = 1'b0;
        b2b = 1'b0;
        chk("b2b_count", acc_cnt - base, 3);
        wait_frame();

        // reset at frame cycle 5, then a clean frame
        send(8'hFF);
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        chk("abort_sout", sout, 0);
        chk("abort_ready", in_ready, 1);
        send(8'h3C);
        wait_frame();

        // loopback detector: all-zero payload fires exactly once on the marker's 0
        yb = y_cnt;
        send(8'h00);
        wait_frame();
        chk("det_count", y_cnt - yb, 1);
        chk("det_cycle", y_at, 3);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
